// File: rtl/pif_ram_controller.sv
// PIF 512x32 word store: N64 word port (A) plus byte-wide housekeeping CPU port (B).
// Optional command interrupt enabled by defining PIF_CMD_IRQ_EN.
module pif_ram_controller (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [8:0]  pif_interface_address,
  input  logic        pif_interface_wren,
  input  logic [31:0] pif_interface_data_out,
  output logic [31:0] pif_interface_data_in,
  input  logic        pif_disable,
  input  logic [10:0] cpu_address,
  input  logic        cpu_wren,
  input  logic        cpu_oe,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_valid,
  output logic        cpu_busy,
  output logic        cmd_irq
);

  localparam logic [8:0] RAM_BASE = 9'h1F0;

  typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;

  state_t      state;
  logic [31:0] mem [512];
  logic [31:0] q_a, q_b, merged, merge_w;
  logic [8:0]  addr_q;
  logic [10:0] op_addr;
  logic [7:0]  op_data;
  logic        op_wr;
  logic [8:0]  op_word;
  logic [1:0]  op_lane;
  logic        a_we, b_we, collide;

  assign op_word = op_addr[10:2];
  assign op_lane = op_addr[1:0];
  assign a_we    = pif_interface_wren && (pif_interface_address >= RAM_BASE);
  assign collide = a_we && (pif_interface_address == op_word);
  // Gated by reset so an op abandoned mid-WR never lands.
  assign b_we    = reset_l && (state == WR) && !collide;

  always_ff @(posedge clk) begin
    if (a_we) mem[pif_interface_address] <= pif_interface_data_out;
    if (b_we) mem[op_word] <= merged;
    q_a <= mem[pif_interface_address];
    q_b <= mem[op_word];
  end

  // Big-endian lanes: lane 0 is bits 31:24.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_comb begin
    merge_w = q_b;
    case (op_lane)
      2'd0:    merge_w[31:24] = op_data;
      2'd1:    merge_w[23:16] = op_data;
      2'd2:    merge_w[15:8]  = op_data;
      default: merge_w[7:0]   = op_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      addr_q                <= '0;
      pif_interface_data_in <= '0;
    end else begin
      addr_q                <= pif_interface_address;
      pif_interface_data_in <= (pif_disable && addr_q < RAM_BASE) ? 32'd0 : q_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state        <= IDLE;
      cpu_data_out <= '0;
      cpu_valid    <= 1'b0;
      cpu_busy     <= 1'b0;
      op_addr      <= '0;
      op_data      <= '0;
      op_wr        <= 1'b0;
      merged       <= '0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: if (cpu_wren || cpu_oe) begin
          op_addr  <= cpu_address;
          op_data  <= cpu_data_in;
          op_wr    <= cpu_wren;
          cpu_busy <= 1'b1;
          state    <= RD;
        end
        RD: state <= collide ? RD : MRG;
        MRG: begin
          if (collide) state <= RD;
          else if (op_wr) begin
            merged <= merge_w;
            state  <= WR;
          end else begin
            cpu_data_out <= lane_byte(q_b, op_lane);
            cpu_valid    <= 1'b1;
            cpu_busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        WR: begin
          if (collide) state <= RD;
          else begin
            cpu_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIF_CMD_IRQ_EN
  localparam logic [8:0] CMD_WORD = 9'h1FF;
  logic irq_set, irq_clr;
  assign irq_set = a_we && (pif_interface_address == CMD_WORD) && pif_interface_data_out[0];
  assign irq_clr = b_we && (op_addr == 11'h7FF);

  always_ff @(posedge clk) begin
    if (!reset_l)     cmd_irq <= 1'b0;
    else if (irq_set) cmd_irq <= 1'b1;
    else if (irq_clr) cmd_irq <= 1'b0;
  end
`else
  assign cmd_irq = 1'b0;
`endif

endmodule

// File: tb/tb_pif_ram_controller.sv
// Directed bench for pif_ram_controller: N64/CPU ports, ROM lockout, collisions, cmd_irq, reset.
module tb_pif_ram_controller;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [8:0]  pif_interface_address = '0;
  logic        pif_interface_wren = 1'b0;
  logic [31:0] pif_interface_data_out = '0;
  logic [31:0] pif_interface_data_in;
  logic        pif_disable = 1'b0;
  logic [10:0] cpu_address = '0;
  logic        cpu_wren = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [7:0]  cpu_data_in = '0;
  logic [7:0]  cpu_data_out;
  logic        cpu_valid;
  logic        cpu_busy;
  logic        cmd_irq;

`ifdef PIF_CMD_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] rd;

  pif_ram_controller dut (
    .clk(clk), .reset_l(reset_l),
    .pif_interface_address(pif_interface_address),
    .pif_interface_wren(pif_interface_wren),
    .pif_interface_data_out(pif_interface_data_out),
    .pif_interface_data_in(pif_interface_data_in),
    .pif_disable(pif_disable),
    .cpu_address(cpu_address), .cpu_wren(cpu_wren), .cpu_oe(cpu_oe),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_valid(cpu_valid), .cpu_busy(cpu_busy), .cmd_irq(cmd_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic n64_wr(input logic [8:0] w, input logic [31:0] d);
    pif_interface_address = w; pif_interface_data_out = d; pif_interface_wren = 1'b1;
    @(negedge clk);
    pif_interface_wren = 1'b0;
  endtask

  task automatic n64_rd(input logic [8:0] w, output logic [31:0] d);
    pif_interface_address = w;
    @(negedge clk);
    @(negedge clk);
    d = pif_interface_data_in;
  endtask

  task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
    cpu_address = a; cpu_data_in = d; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    check("wr_busy_set", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("wr_busy_hold", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    check("wr_busy_clear", {31'd0, cpu_busy}, 32'd0);
  endtask

  task automatic cpu_rd(input logic [10:0] a, output logic [31:0] d);
    cpu_address = a; cpu_oe = 1'b1;
    @(negedge clk);
    cpu_oe = 1'b0;
    check("rd_valid_early0", {31'd0, cpu_valid}, 32'd0);
    @(negedge clk);
    check("rd_valid_early1", {31'd0, cpu_valid}, 32'd0);
    @(negedge clk);
    check("rd_valid", {31'd0, cpu_valid}, 32'd1);
    check("rd_busy_clear", {31'd0, cpu_busy}, 32'd0);
    d = {24'd0, cpu_data_out};
    @(negedge clk);
    check("rd_valid_pulse", {31'd0, cpu_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pif_data_in", pif_interface_data_in, 32'd0);
    check("rst_cpu_data_out", {24'd0, cpu_data_out}, 32'd0);
    check("rst_cpu_valid", {31'd0, cpu_valid}, 32'd0);
    check("rst_cpu_busy", {31'd0, cpu_busy}, 32'd0);
    check("rst_cmd_irq", {31'd0, cmd_irq}, 32'd0);
    reset_l = 1'b1;
    @(negedge clk);

    for (int w = 'h1F0; w <= 'h1FF; w++) n64_wr(w[8:0], 32'd0);

    // CPU byte write then read back, N64 sees the lane in place
    cpu_wr(11'h7C1, 8'hA5);
    cpu_rd(11'h7C1, rd);
    check("cpu_rd_7c1", rd, 32'h0000_00A5);
    n64_rd(9'h1F0, rd);
    check("n64_rd_1f0", rd, 32'h00A5_0000);

    // ROM load via CPU, N64 write dropped, lockout masks ROM only
    cpu_wr(11'h040, 8'h12);
    cpu_wr(11'h041, 8'h34);
    cpu_wr(11'h042, 8'h56);
    cpu_wr(11'h043, 8'h78);
    n64_wr(9'h010, 32'hDEAD_BEEF);
    n64_rd(9'h010, rd);
    check("rom_wr_dropped", rd, 32'h1234_5678);
    pif_disable = 1'b1;
    n64_rd(9'h010, rd);
    check("rom_locked", rd, 32'h0000_0000);
    n64_rd(9'h1F0, rd);
    check("ram_unlocked", rd, 32'h00A5_0000);
    cpu_rd(11'h043, rd);
    check("cpu_rd_unmasked", rd, 32'h0000_0078);
    pif_disable = 1'b0;

    // N64 write visible on the very next read
    n64_wr(9'h1F8, 32'hCAFE_F00D);
    n64_rd(9'h1F8, rd);
    check("n64_wr_rd", rd, 32'hCAFE_F00D);

    // Collision: N64 writes the latched word while the FSM is in MRG
    cpu_address = 11'h7D2; cpu_data_in = 8'h99; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    @(negedge clk);
    pif_interface_address = 9'h1F4; pif_interface_data_out = 32'h1122_3344; pif_interface_wren = 1'b1;
    @(negedge clk);
    pif_interface_wren = 1'b0;
    check("coll_busy0", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("coll_busy1", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    check("coll_done", {31'd0, cpu_busy}, 32'd0);
    n64_rd(9'h1F4, rd);
    check("coll_merge", rd, 32'h1122_9944);

    // Command interrupt: kick, clear by CPU, kick again
    n64_wr(9'h1FF, 32'h0000_0001);
    check("irq_kick", {31'd0, cmd_irq}, IRQ_ON);
    cpu_wr(11'h7FF, 8'h00);
    check("irq_cleared", {31'd0, cmd_irq}, 32'd0);
    n64_wr(9'h1FF, 32'h0000_0001);
    check("irq_kick2", {31'd0, cmd_irq}, IRQ_ON);

    // Re-kick during the clearing WR: write aborts, irq held, then retried
    cpu_address = 11'h7FF; cpu_data_in = 8'h80; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pif_interface_address = 9'h1FF; pif_interface_data_out = 32'h0000_0001; pif_interface_wren = 1'b1;
    @(negedge clk);
    pif_interface_wren = 1'b0;
    check("rekick_irq", {31'd0, cmd_irq}, IRQ_ON);
    check("rekick_busy", {31'd0, cpu_busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rekick_irq_hold", {31'd0, cmd_irq}, IRQ_ON);
    @(negedge clk);
    check("rekick_done", {31'd0, cpu_busy}, 32'd0);
    check("rekick_irq_clr", {31'd0, cmd_irq}, 32'd0);
    n64_rd(9'h1FF, rd);
    check("rekick_word", rd, 32'h0000_0080);

    // Reset during WR: nothing committed, outputs back to reset values
    cpu_address = 11'h7E0; cpu_data_in = 8'h55; cpu_wren = 1'b1;
    @(negedge clk);
    cpu_wren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_l = 1'b0;
    @(negedge clk);
    check("rstwr_busy", {31'd0, cpu_busy}, 32'd0);
    check("rstwr_valid", {31'd0, cpu_valid}, 32'd0);
    check("rstwr_cpu_data", {24'd0, cpu_data_out}, 32'd0);
    check("rstwr_pif_data", pif_interface_data_in, 32'd0);
    check("rstwr_irq", {31'd0, cmd_irq}, 32'd0);
    reset_l = 1'b1;
    @(negedge clk);
    n64_rd(9'h1F8, rd);
    check("rstwr_word", rd, 32'hCAFE_F00D);
    cpu_rd(11'h7E0, rd);
    check("rstwr_cpu_rd", rd, 32'h0000_00CA);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
